div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle 32-bit integer divider sequencer for the MIPS core, serving DIV/DIVU issued from the EX stage. EX raises a start request with both operands. The block latches them, runs a 32-iteration restoring shift-subtract sequence under its own FSM, and returns a 64-bit {remainder, quotient} result with a ready flag. While the divide is in flight, EX holds its stall request, and EX writes the result into HI/LO.

## Interface
Parameters:
- none; widths come from the shared defines (`REG_DATA_WIDTH` = 32).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  divide request from EX; held high until ready_o is seen
- annul_i  in  1  cancel in-flight divide (flush/exception); highest priority after reset
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start
- opdata1_i  in  32  dividend; sampled at the accepting edge
- opdata2_i  in  32  divisor; sampled at the accepting edge
- result_o  out  64  {remainder[63:32], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, BY_ZERO, ON, END.
- Transition priority at every edge: rst_n low, then annul_i, then normal transitions.
- **IDLE:** if start_i=1 and annul_i=0, accept.
  - Latch the signed flag and operand signs.
  - Latch |op1| and |op2| when signed_i=1, raw values otherwise.
  - If the divisor is 0 (see Configuration), go to BY_ZERO; otherwise go to ON with cnt=0.
  - Working register: 65 bits, initialised to {32'b0, |op1|, 1'b0}.
- **ON:** one iteration per edge.
  - Trial-subtract |op2| from the upper 33 bits.
  - Non-negative trial: shift in 1 and keep the difference.
  - Negative trial: shift in 0 and keep the old value.
  - cnt increments each iteration; 6-bit counter, no wrap.
  - On the iteration with cnt==31, go to END and register result_o with sign correction applied:
    - quotient negated when signed_i=1 and op1[31]^op2[31]
    - remainder negated when signed_i=1 and op1[31]=1
- **BY_ZERO:** next edge goes to END with result_o=0.
- **END:** ready_o=1 and result_o stays stable while start_i=1. The first edge with start_i=0 goes to IDLE, ready_o=0, result_o=0.
- **annul_i=1 in any non-IDLE state:** next edge goes to IDLE, ready_o=0, result_o=0, no result produced. annul_i=1 in IDLE blocks acceptance.
- start_i changes while busy are ignored; operands are never re-sampled after acceptance.
- Arithmetic rules:
  - All negation is two's complement modulo 2^32.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0.

## Timing
- Reset values: state=IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0.
- Normal divide: accepting edge E0; iterations on E1..E32; ready_o high after E32. That is a 32-edge latency from acceptance; busy_o is high from after E0.
- Divide by zero (macro defined): ready_o high after E1.
- Back-to-back: a new start is accepted no earlier than the edge after the return to IDLE. Minimum 1 idle cycle between divides.
- Reset asserted mid-operation: the next edge forces all reset values; the partial result is discarded.

## Configuration
- `DIV_BY_ZERO_FAST_EN` defined: divisor==0 routes to BY_ZERO. Result is 0, ready after 2 edges.
- Macro not defined: divisor==0 runs the full 32 iterations.
  - Raw quotient is 0xFFFFFFFF and raw remainder is |op1|, then normal sign correction applies.
  - Example: signed -5/0 gives quotient 0x00000001, remainder 0xFFFFFFFB.
  - Latency is 32 edges.

## Structure
- Shared defines file holds:
  - FSM state encodings (DIV_IDLE, DIV_BY_ZERO, DIV_ON, DIV_END)
  - DIV_ITER_CNT=32
  - DIV_RESULT_WIDTH=64
  - the start/stop level constants that EX also uses
- One sub-module, div_step: combinational single iteration.
  - Inputs: 65-bit working register and 32-bit divisor.
  - Output: next working register.
  - Can be unit-tested in isolation.
- div_seq owns the FSM, counter, operand latch, sign correction and output registers.

## Test plan
- Unsigned 100/7, signed_i=0:
  - ready_o rises exactly 32 edges after acceptance.
  - result_o = 0x00000002_0000000E (remainder 2, quotient 14).
- Signed -7/2 (0xFFFFFFF9 / 0x00000002), signed_i=1:
  - result_o = 0xFFFFFFFF_FFFFFFFD (remainder -1, quotient -3).
  - The same operands with signed_i=0 give quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, 0x00000005/0:
  - With `DIV_BY_ZERO_FAST_EN`: ready after 2 edges, result 0.
  - Without the macro: ready after 32 edges, result 0x00000005_FFFFFFFF.
- Annul on the 10th iteration: next edge gives busy_o=0, ready_o=0, result_o=0. A fresh 9/3 started afterwards returns 0x00000000_00000003 with the normal latency.
- Hold start_i high 5 cycles in END: ready_o and result_o stay stable throughout. Dropping start_i returns the block to IDLE with outputs 0 on the next edge.
- rst_n low for one edge mid-divide: all outputs 0 and state IDLE on the next edge. Operand changes during ON never alter the result.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared defines for the sequential divider: widths, FSM encodings,
// iteration count and the start/stop levels shared with EX.
package div_seq_pkg;

  localparam int REG_DATA_WIDTH   = 32;
  localparam int DIV_ITER_CNT     = 32;
  localparam int DIV_RESULT_WIDTH = 64;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider request/result bundle.
// master = EX stage, slave = divider.
interface div_seq_if;
  import div_seq_pkg::*;

  logic                        start_i;
  logic                        annul_i;
  logic                        signed_i;
  logic [REG_DATA_WIDTH-1:0]   opdata1_i;
  logic [REG_DATA_WIDTH-1:0]   opdata2_i;
  logic [DIV_RESULT_WIDTH-1:0] result_o;
  logic                        ready_o;
  logic                        busy_o;

  modport master (
    output start_i, annul_i, signed_i,
    output opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i,
    input  opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the 65-bit working register.
// Layout: [64:33] partial remainder, [32:1] dividend bits, [0] quotient bit.
module div_step
  import div_seq_pkg::*;
(
  input  logic [64:0]               work,
  input  logic [REG_DATA_WIDTH-1:0] divisor,
  output logic [64:0]               work_next
);

  logic        ge;
  logic [31:0] diff;

  // when the trial is non-negative the true difference fits in 32 bits
  assign ge   = work[64:32] >= {1'b0, divisor};
  assign diff = work[63:32] - divisor;

  assign work_next = ge ? {diff, work[31:0], 1'b1}
                        : {work[63:0], 1'b0};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle 32-bit DIV/DIVU sequencer with 3-process FSM.
// Optional DIV_BY_ZERO_FAST_EN: zero divisor short-cuts to a zero result.
module div_seq
  import div_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  div_seq_if.slave   bus
);

  div_state_t state, state_nxt;

  logic [5:0]  cnt, cnt_nxt;
  logic [64:0] work, work_nxt;
  logic [31:0] dvs, dvs_nxt;
  logic        sgn, sgn_nxt;
  logic        neg1, neg1_nxt;
  logic        neg2, neg2_nxt;
  logic [63:0] result, result_nxt;
  logic        ready, ready_nxt;
  logic        busy;

  logic [64:0] step_out;
  logic [31:0] abs1, abs2;
  logic [31:0] quo, rem, quo_c, rem_c;
  logic        accept;

  div_step u_step (
    .work      (work),
    .divisor   (dvs),
    .work_next (step_out)
  );

  assign accept = (state == DIV_IDLE) &&
                  (bus.start_i == DIV_START) &&
                  !bus.annul_i;

  assign abs1 = (bus.signed_i && bus.opdata1_i[31]) ?
                (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
  assign abs2 = (bus.signed_i && bus.opdata2_i[31]) ?
                (~bus.opdata2_i + 32'd1) : bus.opdata2_i;

  assign quo   = step_out[31:0];
  assign rem   = step_out[64:33];
  assign quo_c = (sgn && (neg1 ^ neg2)) ? (~quo + 32'd1) : quo;
  assign rem_c = (sgn && neg1) ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      work   <= '0;
      dvs    <= '0;
      sgn    <= 1'b0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      work   <= work_nxt;
      dvs    <= dvs_nxt;
      sgn    <= sgn_nxt;
      neg1   <= neg1_nxt;
      neg2   <= neg2_nxt;
      result <= result_nxt;
      ready  <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.annul_i && state != DIV_IDLE) begin
      state_nxt = DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (accept) begin
`ifdef DIV_BY_ZERO_FAST_EN
            if (bus.opdata2_i == 32'd0)
              state_nxt = DIV_BY_ZERO;
            else
              state_nxt = DIV_ON;
`else
            state_nxt = DIV_ON;
`endif
          end
        end
        DIV_BY_ZERO: state_nxt = DIV_END;
        DIV_ON: begin
          if (cnt == 6'(DIV_ITER_CNT - 1))
            state_nxt = DIV_END;
        end
        DIV_END: begin
          if (bus.start_i == DIV_STOP)
            state_nxt = DIV_IDLE;
        end
        default: state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt    = cnt;
    work_nxt   = work;
    dvs_nxt    = dvs;
    sgn_nxt    = sgn;
    neg1_nxt   = neg1;
    neg2_nxt   = neg2;
    result_nxt = result;
    ready_nxt  = ready;
    busy       = (state != DIV_IDLE);
    if (bus.annul_i && state != DIV_IDLE) begin
      cnt_nxt    = '0;
      result_nxt = '0;
      ready_nxt  = 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (accept) begin
            sgn_nxt  = bus.signed_i;
            neg1_nxt = bus.opdata1_i[31];
            neg2_nxt = bus.opdata2_i[31];
            dvs_nxt  = abs2;
            work_nxt = {32'd0, abs1, 1'b0};
            cnt_nxt  = '0;
          end
        end
        DIV_BY_ZERO: begin
          result_nxt = '0;
          ready_nxt  = 1'b1;
        end
        DIV_ON: begin
          work_nxt = step_out;
          cnt_nxt  = cnt + 6'd1;
          if (cnt == 6'(DIV_ITER_CNT - 1)) begin
            result_nxt = {rem_c, quo_c};
            ready_nxt  = 1'b1;
          end
        end
        DIV_END: begin
          if (bus.start_i == DIV_STOP) begin
            result_nxt = '0;
            ready_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = busy;

endmodule

// File: tb/tb_div_seq.sv
// Directed test of div_seq: latency, signed/unsigned results, divide by
// zero, annul, END hold, mid-divide reset.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  div_seq_if bus();

  div_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".busy"},   64'(bus.busy_o),  64'd0);
    chk({tag, ".ready"},  64'(bus.ready_o), 64'd0);
    chk({tag, ".result"}, bus.result_o,     64'd0);
  endtask

  task automatic run_div(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic sgn,
                         input logic [63:0] exp_res,
                         input int exp_lat,
                         input int hold);
    int n;
    bus.start_i   = 1'b1;
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    tick();
    chk({tag, ".busy"}, 64'(bus.busy_o), 64'd1);
    bus.opdata1_i = 32'hDEAD_BEEF;
    bus.opdata2_i = 32'h0000_0003;
    bus.signed_i  = ~sgn;
    n = 0;
    while (!bus.ready_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'(exp_lat));
    chk({tag, ".res"}, bus.result_o, exp_res);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_rdy"}, 64'(bus.ready_o), 64'd1);
      chk({tag, ".hold_res"}, bus.result_o, exp_res);
    end
    bus.start_i = 1'b0;
    tick();
    idle_chk({tag, ".drop"});
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start_i   = 1'b0;
    bus.annul_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    tick();
    tick();
    idle_chk("reset");
    rst_n = 1'b1;
    tick();

    run_div("u100_7", 32'd100, 32'd7, 1'b0,
            64'h00000002_0000000E, 32, 0);
    run_div("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
            64'hFFFFFFFF_FFFFFFFD, 32, 0);
    run_div("u-7_2", 32'hFFFFFFF9, 32'd2, 1'b0,
            64'h00000001_7FFFFFFC, 32, 0);
    run_div("s7_-2", 32'd7, 32'hFFFFFFFE, 1'b1,
            64'h00000001_FFFFFFFD, 32, 0);
    run_div("smin_-1", 32'h80000000, 32'hFFFFFFFF, 1'b1,
            64'h00000000_80000000, 32, 0);
`ifdef DIV_BY_ZERO_FAST_EN
    run_div("u5_0", 32'd5, 32'd0, 1'b0, 64'd0, 1, 0);
    run_div("s-5_0", 32'hFFFFFFFB, 32'd0, 1'b1, 64'd0, 1, 0);
`else
    run_div("u5_0", 32'd5, 32'd0, 1'b0,
            64'h00000005_FFFFFFFF, 32, 0);
    run_div("s-5_0", 32'hFFFFFFFB, 32'd0, 1'b1,
            64'hFFFFFFFB_00000001, 32, 0);
`endif

    run_div("hold", 32'd1000, 32'd10, 1'b0,
            64'h00000000_00000064, 32, 5);

    // annul while idle must block acceptance
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    tick();
    chk("annul_idle.busy", 64'(bus.busy_o), 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // annul on the 10th iteration
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    tick();
    for (int i = 0; i < 9; i++) tick();
    chk("annul.busy_before", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    idle_chk("annul");
    bus.annul_i = 1'b0;
    tick();
    run_div("after_annul", 32'd9, 32'd3, 1'b0,
            64'h00000000_00000003, 32, 0);

    // reset in the middle of a divide
    bus.start_i   = 1'b1;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    tick();
    idle_chk("midrst");
    rst_n = 1'b1;
    tick();
    run_div("after_rst", 32'd77, 32'd5, 1'b0,
            64'h00000002_0000000F, 32, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
